// File: rtl/tlc_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler.
//   colors        : lamp colour driven to each vehicle head
//   phase_t       : requester / phase index (EW straight, EW left, NS, pedestrian)
//   sched_state_t : scheduler state
//   cnt_width()   : counter width derived from the largest timing parameter
package tlc_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } colors;

  typedef enum logic [1:0] {
    PH_EWS = 2'd0,
    PH_EWL = 2'd1,
    PH_NS  = 2'd2,
    PH_PED = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK
  } sched_state_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e, input int unsigned f);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Request/lamp bundle between the sensor side and the phase scheduler.
//   req           : level requests [0] EW straight, [1] EW left, [2] NS, [3] pedestrian
//   ew_str_light  : EW straight lamp
//   ew_left_light : EW left lamp
//   ns_light      : NS lamp
//   walk          : pedestrian walk lamp
//   grant         : one-hot phase currently in green/walk, 0 otherwise
// master = requester/lamp-driver side, slave = scheduler.
interface tlc_phase_scheduler_if;
  import tlc_phase_scheduler_pkg::*;

  logic [3:0] req;
  colors      ew_str_light;
  colors      ew_left_light;
  colors      ns_light;
  logic       walk;
  logic [3:0] grant;

  modport master (
    output req,
    input  ew_str_light, ew_left_light, ns_light, walk, grant
  );

  modport slave (
    input  req,
    output ew_str_light, ew_left_light, ns_light, walk, grant
  );

endinterface

// File: rtl/tlc_rr_pick.sv
// Combinational 4-way round-robin picker.
//   pending : request vector
//   rr_last : most recently served phase; search starts at rr_last+1
//   valid   : some pending bit is set
//   sel     : first set bit in rr_last+1, rr_last+2, ... (mod 4)
module tlc_rr_pick
  import tlc_phase_scheduler_pkg::*;
(
  input  logic [3:0] pending,
  input  phase_t     rr_last,
  output logic       valid,
  output phase_t     sel
);

  logic [1:0] idx;

  always_comb begin
    valid = 1'b0;
    sel   = rr_last;
    idx   = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = rr_last + 2'(i);
      if (!valid && pending[idx]) begin
        valid = 1'b1;
        sel   = phase_t'(idx);
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Round-robin phase scheduler: EW straight, EW left, NS and a pedestrian crossing share
// the intersection. Latches requests, enforces min/max green, gap-out, yellow, all-red.
//   clk, reset : clock, synchronous active-high reset
//   preempt    : (only with TLC_PREEMPT_EN defined) force the current phase out
//   bus        : tlc_phase_scheduler_if.slave (req in; lamps, walk, grant out)
module tlc_phase_scheduler
  import tlc_phase_scheduler_pkg::*;
#(
  parameter int unsigned MIN_GRN  = 3,
  parameter int unsigned GAP_CYC  = 5,
  parameter int unsigned MAX_GRN  = 10,
  parameter int unsigned YEL_CYC  = 2,
  parameter int unsigned AR_CYC   = 1,
  parameter int unsigned WALK_CYC = 6
) (
  input logic clk,
  input logic reset,
`ifdef TLC_PREEMPT_EN
  input logic preempt,
`endif
  tlc_phase_scheduler_if.slave bus
);

  localparam int unsigned CntW = cnt_width(MIN_GRN, GAP_CYC, MAX_GRN, YEL_CYC, AR_CYC,
                                           WALK_CYC);
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t MinGrn  = cnt_t'(MIN_GRN);
  localparam cnt_t GapCyc  = cnt_t'(GAP_CYC);
  localparam cnt_t MaxGrn  = cnt_t'(MAX_GRN);
  localparam cnt_t YelEnd  = cnt_t'(YEL_CYC - 1);
  localparam cnt_t ArEnd   = cnt_t'(AR_CYC - 1);
  localparam cnt_t WalkEnd = cnt_t'(WALK_CYC - 1);

  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    return (v >= lim) ? v : v + cnt_t'(1);
  endfunction

  logic preempt_w;
`ifdef TLC_PREEMPT_EN
  assign preempt_w = preempt;
`else
  assign preempt_w = 1'b0;
`endif

  sched_state_t state_q, state_d;
  phase_t       phase_q, phase_d;
  phase_t       rr_last_q, rr_last_d;
  logic [3:0]   pending_q, pending_d;
  cnt_t         grn_q, grn_d, gap_q, gap_d, max_q, max_d, tmr_q, tmr_d;

  logic         pick_valid;
  phase_t       pick_sel;
  logic         arb;
  logic         conflict;
  logic [3:0]   grant_w;
  colors        lamp;

  tlc_rr_pick u_rr_pick (
    .pending (pending_q),
    .rr_last (rr_last_q),
    .valid   (pick_valid),
    .sel     (pick_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_EWS;
      rr_last_q <= PH_PED;
      pending_q <= '0;
      grn_q     <= '0;
      gap_q     <= '0;
      max_q     <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rr_last_q <= rr_last_d;
      pending_q <= pending_d;
      grn_q     <= grn_d;
      gap_q     <= gap_d;
      max_q     <= max_d;
      tmr_q     <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rr_last_d = rr_last_q;
    grn_d     = grn_q;
    gap_d     = gap_q;
    max_d     = max_q;
    tmr_d     = tmr_q;
    arb       = 1'b0;
    // The served phase's own request is ignored while it holds the right of way.
    pending_d = pending_q | (bus.req & ~grant_w);
    conflict  = |((pending_q | bus.req) & ~grant_w);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && !preempt_w) arb = 1'b1;
      end
      ST_GREEN: begin
        grn_d = sat_inc(grn_q, MinGrn);
        gap_d = bus.req[phase_q] ? '0 : sat_inc(gap_q, GapCyc);
        // Once started, max_ctr keeps running even if the competitor drops.
        if (max_q != '0 || conflict) max_d = sat_inc(max_q, MaxGrn);
        if (preempt_w || (grn_q >= MinGrn && (gap_q == GapCyc || max_q == MaxGrn))) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        tmr_d = sat_inc(tmr_q, '1);
        if (tmr_q == YelEnd) state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        tmr_d = sat_inc(tmr_q, '1);
        if (preempt_w) begin
          tmr_d = '0;
        end else if (tmr_q == ArEnd) begin
          // End of clearance doubles as the arbitration point.
          if (pick_valid) arb = 1'b1;
          else            state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        tmr_d = sat_inc(tmr_q, '1);
        if (preempt_w || tmr_q == WalkEnd) state_d = ST_ALLRED;
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb) begin
      state_d             = (pick_sel == PH_PED) ? ST_WALK : ST_GREEN;
      phase_d             = pick_sel;
      rr_last_d           = pick_sel;
      pending_d[pick_sel] = 1'b0;
    end

    if (state_d != state_q) begin
      grn_d = '0;
      gap_d = '0;
      max_d = '0;
      tmr_d = '0;
    end
  end

  // Moore outputs from registered state only.
  always_comb begin
    lamp     = RED;
    grant_w  = '0;
    bus.walk = 1'b0;
    unique case (state_q)
      ST_GREEN: begin
        lamp    = GREEN;
        grant_w = 4'b0001 << phase_q;
      end
      ST_YELLOW: lamp = YELLOW;
      ST_WALK: begin
        bus.walk = 1'b1;
        grant_w  = 4'b0001 << phase_q;
      end
      default: lamp = RED;
    endcase
    bus.ew_str_light  = RED;
    bus.ew_left_light = RED;
    bus.ns_light      = RED;
    if (phase_q == PH_EWS) bus.ew_str_light  = lamp;
    if (phase_q == PH_EWL) bus.ew_left_light = lamp;
    if (phase_q == PH_NS)  bus.ns_light      = lamp;
    bus.grant = grant_w;
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: directed scenarios plus a randomized run checked
// against a time-based reference model of the scheduling rules.
module tb_tlc_phase_scheduler;
  import tlc_phase_scheduler_pkg::*;

  localparam int MIN = 3, GAP = 5, MAXG = 10, YEL = 2, AR = 1, WLK = 6;

  logic clk;
  logic reset;
  logic pre;
  int   checks = 0;
  int   errors = 0;

  tlc_phase_scheduler_if bus();

  tlc_phase_scheduler #(
    .MIN_GRN  (MIN),
    .GAP_CYC  (GAP),
    .MAX_GRN  (MAXG),
    .YEL_CYC  (YEL),
    .AR_CYC   (AR),
    .WALK_CYC (WLK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef TLC_PREEMPT_EN
    .preempt (pre),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    pre     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: segment kind + age, with gap/max derived from event ages.
  int         m_seg;        // 0 idle, 1 green, 2 yellow, 3 all-red, 4 walk
  int         m_ph, m_age, m_rr, m_last_own, m_cstart;
  logic [3:0] m_pend;

  task automatic model_reset();
    m_seg = 0; m_ph = 0; m_age = 0; m_rr = 3; m_pend = 4'b0;
    m_last_own = -1; m_cstart = -1;
  endtask

  task automatic model_step(input logic [3:0] r, input logic p);
    logic [3:0] served;
    int nxt, pick, gap, mx, idx;
    bit arb;
    served = (m_seg == 1 || m_seg == 4) ? 4'(1 << m_ph) : 4'b0;
    nxt = m_seg;
    arb = 0;
    case (m_seg)
      0: arb = !p;
      1: begin
        gap = m_age - m_last_own - 1;
        mx  = (m_cstart < 0) ? 0 : m_age - m_cstart;
        if (p || (m_age >= MIN && (gap >= GAP || mx >= MAXG))) nxt = 2;
        if (r[m_ph]) m_last_own = m_age;
        if (m_cstart < 0 && ((m_pend | r) & ~served) != 4'b0) m_cstart = m_age;
      end
      2: if (m_age == YEL - 1) nxt = 3;
      3: if (!p && m_age == AR - 1) arb = 1;
      4: if (p || m_age == WLK - 1) nxt = 3;
      default: nxt = 0;
    endcase
    pick = -1;
    if (arb) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_rr + k) % 4;
        if (pick < 0 && m_pend[idx]) pick = idx;
      end
      if (pick < 0) nxt = 0;
    end
    m_pend = m_pend | (r & ~served);
    if (pick >= 0) begin
      m_pend[pick] = 1'b0;
      m_ph = pick;
      m_rr = pick;
      nxt = (pick == 3) ? 4 : 1;
      m_last_own = -1;
      m_cstart = -1;
    end
    if (nxt != m_seg || (m_seg == 3 && p)) m_age = 0;
    else m_age++;
    m_seg = nxt;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 4'b1111;
    pre     = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.grant !== 4'b0 || bus.walk !== 1'b0 || bus.ew_str_light !== RED ||
        bus.ew_left_light !== RED || bus.ns_light !== RED) begin
      errors++;
      $display("FAIL reset_state: grant=%b walk=%b lights=%0d/%0d/%0d required 0000/0/all red",
               bus.grant, bus.walk, bus.ew_str_light, bus.ew_left_light, bus.ns_light);
    end
    reset   = 1'b0;
    bus.req = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0) begin
        errors++;
        $display("FAIL reset_no_pending c=%0d grant=%b required 0000", c, bus.grant);
      end
    end
  endtask

  task automatic test_gap_out();
    colors exp;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.req = (c < 4) ? 4'b0001 : 4'b0000;
      if (c >= 2 && c <= 9)       exp = GREEN;
      else if (c == 10 || c == 11) exp = YELLOW;
      else                         exp = RED;
      checks++;
      if (bus.ew_str_light !== exp ||
          bus.grant !== ((exp == GREEN) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL gap_out c=%0d light=%0d grant=%b required light=%0d", c,
                 bus.ew_str_light, bus.grant, exp);
      end
      tick();
    end
  endtask

  task automatic test_max_green();
    colors exp;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      bus.req = (c < 2) ? 4'b0100 : 4'b0101;
      if (c >= 2 && c <= 12)       exp = GREEN;
      else if (c == 13 || c == 14) exp = YELLOW;
      else                         exp = RED;
      checks++;
      if (bus.ns_light !== exp) begin
        errors++;
        $display("FAIL max_green c=%0d ns=%0d required %0d", c, bus.ns_light, exp);
      end
      if (c == 16) begin
        checks++;
        if (bus.ew_str_light !== GREEN || bus.grant !== 4'b0001) begin
          errors++;
          $display("FAIL max_green_next ews=%0d grant=%b required GREEN/0001",
                   bus.ew_str_light, bus.grant);
        end
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_g;
    logic exp_w, exp_y, got_y;
    int st;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      bus.req = (c == 0) ? 4'b1111 : 4'b0000;
      exp_g = 4'b0;
      exp_y = 1'b0;
      for (int i = 0; i < 4; i++) begin
        st = 2 + 9 * i;
        if (c >= st && c < st + 6) exp_g = 4'(1 << i);
        if (i < 3 && (c == st + 6 || c == st + 7)) exp_y = 1'b1;
      end
      exp_w = (c >= 29 && c <= 34);
      got_y = (bus.ew_str_light == YELLOW) || (bus.ew_left_light == YELLOW) ||
              (bus.ns_light == YELLOW);
      checks++;
      if (bus.grant !== exp_g || bus.walk !== exp_w || got_y !== exp_y) begin
        errors++;
        $display("FAIL all_four c=%0d grant=%b walk=%b yellow=%b required %b/%b/%b", c,
                 bus.grant, bus.walk, got_y, exp_g, exp_w, exp_y);
      end
      tick();
    end
  endtask

  task automatic test_min_green();
    colors exp;
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      bus.req = (c == 0) ? 4'b0110 : 4'b0100;
      if (c >= 2 && c <= 7)      exp = GREEN;
      else if (c == 8 || c == 9) exp = YELLOW;
      else                       exp = RED;
      checks++;
      if (bus.ew_left_light !== exp) begin
        errors++;
        $display("FAIL min_green c=%0d ewl=%0d required %0d", c, bus.ew_left_light, exp);
      end
      if (c == 11) begin
        checks++;
        if (bus.ns_light !== GREEN || bus.grant !== 4'b0100) begin
          errors++;
          $display("FAIL min_green_next ns=%0d grant=%b required GREEN/0100",
                   bus.ns_light, bus.grant);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      bus.req = (c == 0) ? 4'b1100 : 4'b0000;
      if (c == 8) begin
        checks++;
        if (bus.ns_light !== YELLOW) begin
          errors++;
          $display("FAIL reset_mid_setup ns=%0d required YELLOW", bus.ns_light);
        end
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    checks++;
    if (bus.grant !== 4'b0 || bus.walk !== 1'b0 || bus.ew_str_light !== RED ||
        bus.ew_left_light !== RED || bus.ns_light !== RED) begin
      errors++;
      $display("FAIL reset_mid grant=%b walk=%b ns=%0d required all red", bus.grant,
               bus.walk, bus.ns_light);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0 || bus.walk !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_lost c=%0d grant=%b walk=%b required 0000/0", c,
                 bus.grant, bus.walk);
      end
    end
  endtask

`ifdef TLC_PREEMPT_EN
  task automatic test_preempt();
    logic all_red;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      bus.req = (c == 0) ? 4'b0111 : 4'b0000;
      pre     = (c >= 2 && c <= 5);
      all_red = (bus.ew_str_light == RED) && (bus.ew_left_light == RED) &&
                (bus.ns_light == RED) && (bus.grant == 4'b0);
      if (c == 3 || c == 4) begin
        checks++;
        if (bus.ew_str_light !== YELLOW) begin
          errors++;
          $display("FAIL preempt_yellow c=%0d ews=%0d required YELLOW", c, bus.ew_str_light);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (!all_red) begin
          errors++;
          $display("FAIL preempt_allred c=%0d grant=%b required all red", c, bus.grant);
        end
      end
      if (c == 7 || c == 16) begin
        checks++;
        if (bus.grant !== ((c == 7) ? 4'b0010 : 4'b0100)) begin
          errors++;
          $display("FAIL preempt_order c=%0d grant=%b", c, bus.grant);
        end
      end
      tick();
    end
    pre = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] r, exp_g;
    logic p, exp_w;
    colors exp_l [3];
    colors got_l [3];
    do_reset();
    model_reset();
    r = 4'b0;
    for (int n = 0; n < 3000; n++) begin
      exp_g = (m_seg == 1 || m_seg == 4) ? 4'(1 << m_ph) : 4'b0;
      exp_w = (m_seg == 4);
      for (int i = 0; i < 3; i++) begin
        exp_l[i] = RED;
        if (m_ph == i && m_seg == 1) exp_l[i] = GREEN;
        if (m_ph == i && m_seg == 2) exp_l[i] = YELLOW;
      end
      got_l[0] = bus.ew_str_light;
      got_l[1] = bus.ew_left_light;
      got_l[2] = bus.ns_light;
      checks++;
      if (bus.grant !== exp_g) begin
        errors++;
        $display("FAIL random_grant n=%0d grant=%b required %b", n, bus.grant, exp_g);
      end
      checks++;
      if (bus.walk !== exp_w) begin
        errors++;
        $display("FAIL random_walk n=%0d walk=%b required %b", n, bus.walk, exp_w);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL random_light%0d n=%0d light=%0d required %0d", i, n, got_l[i],
                   exp_l[i]);
        end
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      p = 1'b0;
`ifdef TLC_PREEMPT_EN
      p = ($urandom_range(0, 40) == 0);
`endif
      bus.req = r;
      pre     = p;
      model_step(r, p);
      tick();
    end
    pre = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = 4'b0000;
    pre     = 1'b0;
    test_reset();
    test_gap_out();
    test_max_green();
    test_all_four();
    test_min_green();
    test_reset_mid();
`ifdef TLC_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
